// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register with ALU, a 3-cycle multiplier sequence and flush.
// Define EXE_MEM_OVF_EN to enable the signed ADD/SUB overflow trap.
module exe_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_RegWrite,
    input  logic        EXE_mem_to_reg,
    input  logic        EXE_memwrite,
    input  logic        EXE_jal,
    input  logic        EXE_alua,
    input  logic        EXE_alub,
    input  logic [3:0]  EXE_aluOp,
    input  logic [4:0]  EXE_writereg_num,
    input  logic [31:0] EXE_PC,
    input  logic [31:0] EXE_A,
    input  logic [31:0] EXE_B,
    input  logic [31:0] EXE_IMM32,
    input  logic        flush,
    output logic        exe_busy,
    output logic        MEM_RegWrite,
    output logic        MEM_mem_to_reg,
    output logic        MEM_memwrite,
    output logic [4:0]  MEM_writereg_num,
    output logic [31:0] MEM_alu_result,
    output logic [31:0] MEM_store_data,
    output logic        MEM_ovf
);

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd12;

    state_t      state;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_res;
    logic [31:0] result;
    logic        is_mul;
    logic        do_load;
    logic        ovf_hit;

    assign op_a = EXE_alua ? {27'b0, EXE_IMM32[10:6]} : EXE_A;
    assign op_b = EXE_alub ? EXE_IMM32 : EXE_B;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        alu_res = '0;
        unique case (EXE_aluOp)
            4'd0:    alu_res = sum;
            4'd1:    alu_res = diff;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = ~(op_a | op_b);
            4'd6:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            4'd7:    alu_res = {31'b0, op_a < op_b};
            4'd8:    alu_res = op_b << op_a[4:0];
            4'd9:    alu_res = op_b >> op_a[4:0];
            4'd10:   alu_res = $signed(op_b) >>> op_a[4:0];
            4'd11:   alu_res = {op_b[15:0], 16'b0};
            4'd12:   alu_res = op_a * op_b;
            default: alu_res = '0;
        endcase
    end

    assign result  = EXE_jal ? EXE_PC : alu_res;
    assign is_mul  = (EXE_aluOp == OP_MUL);
    assign cnt_nxt = cnt + 2'd1;

    // Busy depends only on state and opcode so flush never loops back upstream
    assign exe_busy = rst && ((state == MUL_BUSY) || is_mul);

    always_comb begin
        do_load = 1'b0;
        unique case (state)
            IDLE:     do_load = !flush && !is_mul;
            MUL_BUSY: do_load = !flush && (cnt_nxt == 2'd2);
        endcase
    end

`ifdef EXE_MEM_OVF_EN
    always_comb begin
        ovf_hit = 1'b0;
        if (!EXE_jal && EXE_aluOp == OP_ADD)
            ovf_hit = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
        else if (!EXE_jal && EXE_aluOp == OP_SUB)
            ovf_hit = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            MEM_ovf <= 1'b0;
        else if (do_load && ovf_hit)
            MEM_ovf <= 1'b1;
    end
`else
    assign ovf_hit = 1'b0;
    assign MEM_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= 2'd0;
            MEM_RegWrite     <= 1'b0;
            MEM_mem_to_reg   <= 1'b0;
            MEM_memwrite     <= 1'b0;
            MEM_writereg_num <= 5'd0;
            MEM_alu_result   <= 32'd0;
            MEM_store_data   <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!flush && is_mul) begin
                        state <= MUL_BUSY;
                        cnt   <= 2'd0;
                    end
                end
                MUL_BUSY: begin
                    if (flush || cnt_nxt == 2'd2) begin
                        state <= IDLE;
                        cnt   <= 2'd0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
            endcase

            if (do_load) begin
                MEM_RegWrite     <= EXE_RegWrite && !ovf_hit;
                MEM_mem_to_reg   <= EXE_mem_to_reg;
                MEM_memwrite     <= EXE_memwrite;
                MEM_writereg_num <= EXE_writereg_num;
                MEM_alu_result   <= result;
                MEM_store_data   <= EXE_B;
            end else begin
                MEM_RegWrite     <= 1'b0;
                MEM_mem_to_reg   <= 1'b0;
                MEM_memwrite     <= 1'b0;
                MEM_writereg_num <= 5'd0;
                MEM_alu_result   <= 32'd0;
                MEM_store_data   <= 32'd0;
            end
        end
    end

endmodule

// File: doc/exe_mem_stage.md
EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: EXE_RegWrite, EXE_mem_to_reg, EXE_memwrite, EXE_jal, EXE_alua, EXE_alub  in  1 each  control from EXE register.
REQ-004 SHALL have: EXE_aluOp  in  4  ALU op; EXE_writereg_num  in  5  destination register.
REQ-005 SHALL have: EXE_PC (already PC+4), EXE_A, EXE_B, EXE_IMM32  in  32 each  operands.
REQ-006 SHALL have: flush  in  1  kill the instruction currently in EXE (branch taken).
REQ-007 SHALL have: exe_busy  out  1  EXE occupied by multi-cycle MUL; upstream holds EXE inputs.
REQ-008 SHALL have: MEM_RegWrite, MEM_mem_to_reg, MEM_memwrite  out  1 each; MEM_writereg_num  out  5.
REQ-009 SHALL have: MEM_alu_result, MEM_store_data  out  32 each; MEM_ovf  out  1  sticky overflow flag.

Function
REQ-010 SHALL select opA = alua ? {27'b0, EXE_IMM32[10:6]} : EXE_A; opB = alub ? EXE_IMM32 : EXE_B.
REQ-011 SHALL compute by aluOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI {opB[15:0],16'b0}, 12 MUL; 13-15 result 0.
REQ-012 SHALL shift opB by opA[4:0] for SLL/SRL/SRA; ADD/SUB/MUL wrap modulo 2^32; MUL returns low 32 bits of product.
REQ-013 SHALL override result with EXE_PC when EXE_jal=1, regardless of aluOp.
REQ-014 SHALL register result, EXE_B (as MEM_store_data), controls and writereg_num into MEM_* on each rising edge: latency 1 cycle for non-MUL ops.
REQ-015 SHALL implement FSM IDLE/MUL_BUSY with 2-bit counter: in IDLE, aluOp=12 and not flush -> MUL_BUSY, cnt=0, exe_busy=1 combinationally that cycle.
REQ-016 SHALL, in MUL_BUSY, increment cnt each cycle; at cnt=2 latch MUL result with controls into MEM_*, drop exe_busy, return IDLE (3-cycle total latency).
REQ-017 SHALL load a bubble (MEM_RegWrite=0, MEM_memwrite=0, MEM_mem_to_reg=0, writereg_num=0, result=0) every cycle exe_busy=1 without completing.
REQ-018 SHALL load a bubble when flush=1; flush in MUL_BUSY aborts the MUL, returns IDLE next edge, exe_busy deasserts.
REQ-019 SHALL give flush priority over MUL completion in the same cycle.
REQ-020 SHALL keep exe_busy a function of state and EXE_aluOp only (no combinational path from flush to MEM_*).

Reset
REQ-021 SHALL, on rst=0, immediately clear all MEM_* outputs, MEM_ovf, cnt, and enter IDLE; exe_busy=0 while reset asserted.
REQ-022 SHALL abandon an in-progress MUL on reset; first edge after release behaves as IDLE.

Configuration
REQ-023 SHALL honour macro EXE_MEM_OVF_EN: defined -> signed overflow on ADD/SUB forces MEM_RegWrite=0 for that instruction and sets MEM_ovf, held until reset.
REQ-024 SHALL, without EXE_MEM_OVF_EN, tie MEM_ovf to 0 and never suppress MEM_RegWrite on overflow.

Verification
REQ-025 SHALL cover: ADD A=5,B=7,RegWrite=1,wr=3 -> next edge MEM_alu_result=12, MEM_RegWrite=1, MEM_writereg_num=3.
REQ-026 SHALL cover: SRA alua=1, IMM32[10:6]=4, B=0x80000000 -> MEM_alu_result=0xF8000000.
REQ-027 SHALL cover: MUL A=0x10000,B=0x10003 -> exe_busy high 3 cycles, two bubbles, then MEM_alu_result=0x00030000.
REQ-028 SHALL cover: flush asserted in 2nd MUL cycle -> bubble loaded, exe_busy=0 next cycle, no MUL result ever written.
REQ-029 SHALL cover: EXE_MEM_OVF_EN defined, ADD 0x7FFFFFFF+1 -> MEM_RegWrite=0, MEM_ovf=1 until rst=0; undefined -> result 0x80000000, RegWrite=1.
REQ-030 SHALL cover: rst=0 asserted mid-MUL between edges -> all MEM_* 0 immediately, exe_busy=0.
